// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier and optional restoring divider.
// Build option EX_DIV_EN: when defined the divider is built; otherwise funct3 codes 4-7 return 0 in one cycle.
module ex_stage #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32,
   parameter int RIDX_W   = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic                id_ex_valid_i,
   input  logic [PC_WIDTH-1:0] id_ex_pc_i,
   input  logic [XLEN-1:0]     id_ex_alu_op1_i,
   input  logic [XLEN-1:0]     id_ex_alu_op2_i,
   input  logic [3:0]          id_ex_alu_fun_i,
   input  logic                id_ex_mdu_en_i,
   input  logic [RIDX_W-1:0]   id_ex_rd_idx_i,
   input  logic                id_ex_rd_en_i,
   output logic                ex_stall_o,
   output logic                ex_valid_o,
   output logic [PC_WIDTH-1:0] ex_pc_o,
   output logic [XLEN-1:0]     ex_result_o,
   output logic [RIDX_W-1:0]   ex_rd_idx_o,
   output logic                ex_rd_en_o
);
   localparam int SHW = $clog2(XLEN);

   // state | meaning
   // IDLE  | single-cycle ops flow into EX/MEM; a valid iterative op is captured
   // BUSY  | one multiply or divide step per cycle, upstream held
   // DONE  | sign fix-up, result loaded into EX/MEM
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_q;
   logic [SHW-1:0]      cnt_q;
   logic [2*XLEN-1:0]   acc_q, acc_d, prod;
   logic [XLEN-1:0]     mcand_q;
   logic [1:0]          fun_q;
   logic                neg1_q, neg2_q;
   logic [PC_WIDTH-1:0] op_pc_q, pc_q;
   logic [RIDX_W-1:0]   op_rd_idx_q, rd_idx_q;
   logic                op_rd_en_q, valid_q, rd_en_q;
   logic [XLEN-1:0]     result_q;

   logic                start, sgn1, sgn2, neg1, neg2;
   logic [XLEN-1:0]     op1, op2, mag1, mag2, alu_res, sc_res_d, fix_d, mul_res;
   logic [SHW-1:0]      shamt;
   logic [XLEN:0]       mul_sum;

   assign op1 = id_ex_alu_op1_i;
   assign op2 = id_ex_alu_op2_i;

`ifdef EX_DIV_EN
   assign start = id_ex_valid_i & id_ex_mdu_en_i;
`else
   assign start = id_ex_valid_i & id_ex_mdu_en_i & ~id_ex_alu_fun_i[2];
`endif
   assign ex_stall_o = ~rst & ~flush_i & (((state_q == IDLE) & start) | (state_q == BUSY));

   // funct3 signedness: MUL/MULH/MULHSU/DIV/REM treat op1 as signed; only MUL/MULH/DIV/REM op2
   assign sgn1 = id_ex_alu_fun_i[2] ? ~id_ex_alu_fun_i[0] : (id_ex_alu_fun_i[1:0] != 2'd3);
   assign sgn2 = id_ex_alu_fun_i[2] ? ~id_ex_alu_fun_i[0] : ~id_ex_alu_fun_i[1];
   assign neg1 = sgn1 & op1[XLEN-1];
   assign neg2 = sgn2 & op2[XLEN-1];
   assign mag1 = neg1 ? -op1 : op1;
   assign mag2 = neg2 ? -op2 : op2;

   assign shamt = op2[SHW-1:0];
   always_comb begin
      alu_res = '0;
      case (id_ex_alu_fun_i)
         4'd0:    alu_res = op1 + op2;
         4'd1:    alu_res = op1 - op2;
         4'd2:    alu_res = op1 << shamt;
         4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
         4'd4:    alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
         4'd5:    alu_res = op1 ^ op2;
         4'd6:    alu_res = op1 >> shamt;
         4'd7:    alu_res = $unsigned($signed(op1) >>> shamt);
         4'd8:    alu_res = op1 | op2;
         4'd9:    alu_res = op1 & op2;
         4'd10:   alu_res = op2;
         default: alu_res = '0;
      endcase
   end
   assign sc_res_d = id_ex_mdu_en_i ? '0 : alu_res;

   // acc_q is {high, low}: multiplier in low half shifts out as the product shifts in
   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign prod    = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
   assign mul_res = (fun_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef EX_DIV_EN
   logic            div_q, dz_q;
   logic [XLEN:0]   div_shift, div_diff;
   logic [XLEN-1:0] quo, rem, div_res;

   assign div_shift = acc_q[2*XLEN-1:XLEN-1];
   assign div_diff  = div_shift - {1'b0, mcand_q};
   assign quo       = acc_q[XLEN-1:0];
   assign rem       = acc_q[2*XLEN-1:XLEN];
   always_comb begin
      if (!div_q)
         acc_d = {mul_sum, acc_q[XLEN-1:1]};
      else if (div_diff[XLEN])
         acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
         acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   end
   // a zero divisor already leaves |dividend| in rem, so only the quotient needs forcing
   assign div_res = fun_q[1] ? (neg1_q ? -rem : rem)
                             : (dz_q ? '1 : ((neg1_q ^ neg2_q) ? -quo : quo));
   assign fix_d   = div_q ? div_res : mul_res;
`else
   assign acc_d = {mul_sum, acc_q[XLEN-1:1]};
   assign fix_d = mul_res;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         fun_q       <= '0;
         neg1_q      <= 1'b0;
         neg2_q      <= 1'b0;
         op_pc_q     <= '0;
         op_rd_idx_q <= '0;
         op_rd_en_q  <= 1'b0;
         valid_q     <= 1'b0;
         pc_q        <= '0;
         result_q    <= '0;
         rd_idx_q    <= '0;
         rd_en_q     <= 1'b0;
`ifdef EX_DIV_EN
         div_q       <= 1'b0;
         dz_q        <= 1'b0;
`endif
      end else if (flush_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         rd_en_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= BUSY;
                  cnt_q       <= '0;
                  acc_q       <= {{XLEN{1'b0}}, mag1};
                  mcand_q     <= mag2;
                  fun_q       <= id_ex_alu_fun_i[1:0];
                  neg1_q      <= neg1;
                  neg2_q      <= neg2;
                  op_pc_q     <= id_ex_pc_i;
                  op_rd_idx_q <= id_ex_rd_idx_i;
                  op_rd_en_q  <= id_ex_rd_en_i;
                  valid_q     <= 1'b0;
                  rd_en_q     <= 1'b0;
`ifdef EX_DIV_EN
                  div_q       <= id_ex_alu_fun_i[2];
                  dz_q        <= (op2 == '0);
`endif
               end else begin
                  valid_q  <= id_ex_valid_i;
                  pc_q     <= id_ex_pc_i;
                  result_q <= sc_res_d;
                  rd_idx_q <= id_ex_rd_idx_i;
                  rd_en_q  <= id_ex_valid_i & id_ex_rd_en_i;
               end
            end
            BUSY: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == SHW'(XLEN-1))
                  state_q <= DONE;
            end
            DONE: begin
               state_q  <= IDLE;
               cnt_q    <= '0;
               valid_q  <= 1'b1;
               pc_q     <= op_pc_q;
               result_q <= fix_d;
               rd_idx_q <= op_rd_idx_q;
               rd_en_q  <= op_rd_en_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ex_valid_o  = valid_q;
   assign ex_pc_o     = pc_q;
   assign ex_result_o = result_q;
   assign ex_rd_idx_o = rd_idx_q;
   assign ex_rd_en_o  = rd_en_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, iterative MUL/DIV latency and results, flush and reset mid-operation.
module tb_ex_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic        id_ex_valid_i;
   logic [31:0] id_ex_pc_i;
   logic [31:0] id_ex_alu_op1_i;
   logic [31:0] id_ex_alu_op2_i;
   logic [3:0]  id_ex_alu_fun_i;
   logic        id_ex_mdu_en_i;
   logic [4:0]  id_ex_rd_idx_i;
   logic        id_ex_rd_en_i;
   logic        ex_stall_o;
   logic        ex_valid_o;
   logic [31:0] ex_pc_o;
   logic [31:0] ex_result_o;
   logic [4:0]  ex_rd_idx_o;
   logic        ex_rd_en_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] pc_drv   = 32'h0000_1000;
   logic [4:0]  rd_drv   = 5'd1;
   logic        rd_en_drv = 1'b1;

`ifdef EX_DIV_EN
   localparam int DIV_STALL = 33;
   localparam bit DIV_ON    = 1'b1;
`else
   localparam int DIV_STALL = 0;
   localparam bit DIV_ON    = 1'b0;
`endif

   ex_stage #(.XLEN(32), .PC_WIDTH(32), .RIDX_W(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush_i         (flush_i),
      .id_ex_valid_i   (id_ex_valid_i),
      .id_ex_pc_i      (id_ex_pc_i),
      .id_ex_alu_op1_i (id_ex_alu_op1_i),
      .id_ex_alu_op2_i (id_ex_alu_op2_i),
      .id_ex_alu_fun_i (id_ex_alu_fun_i),
      .id_ex_mdu_en_i  (id_ex_mdu_en_i),
      .id_ex_rd_idx_i  (id_ex_rd_idx_i),
      .id_ex_rd_en_i   (id_ex_rd_en_i),
      .ex_stall_o      (ex_stall_o),
      .ex_valid_o      (ex_valid_o),
      .ex_pc_o         (ex_pc_o),
      .ex_result_o     (ex_result_o),
      .ex_rd_idx_o     (ex_rd_idx_o),
      .ex_rd_en_o      (ex_rd_en_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic mdu, input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b);
      pc_drv          = pc_drv + 32'd4;
      rd_drv          = rd_drv + 5'd1;
      id_ex_valid_i   = 1'b1;
      id_ex_pc_i      = pc_drv;
      id_ex_alu_op1_i = a;
      id_ex_alu_op2_i = b;
      id_ex_alu_fun_i = fun;
      id_ex_mdu_en_i  = mdu;
      id_ex_rd_idx_i  = rd_drv;
      id_ex_rd_en_i   = rd_en_drv;
   endtask

   // Present one op, count stall cycles, then check the EX/MEM register on the first free edge.
   task automatic do_op(input string tag, input logic mdu, input logic [3:0] fun,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input logic [31:0] exp_res);
      int n;
      int vbusy;
      @(negedge clk);
      drive(mdu, fun, a, b);
      #1;
      n = 0;
      vbusy = 0;
      while (ex_stall_o && n < 100) begin
         @(negedge clk);
         #1;
         n++;
         if (ex_stall_o && ex_valid_o) vbusy++;
      end
      check({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
      check({tag, "_valid_while_busy"}, 64'(vbusy), 64'd0);
      @(posedge clk);
      #1;
      id_ex_valid_i = 1'b0;
      check({tag, "_valid"}, 64'(ex_valid_o), 64'd1);
      check({tag, "_result"}, 64'(ex_result_o), 64'(exp_res));
      check({tag, "_pc"}, 64'(ex_pc_o), 64'(pc_drv));
      check({tag, "_rd_idx"}, 64'(ex_rd_idx_o), 64'(rd_drv));
      check({tag, "_rd_en"}, 64'(ex_rd_en_o), 64'(rd_en_drv));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int vcount;
      rst = 1'b1;
      flush_i = 1'b0;
      id_ex_valid_i = 1'b0;
      id_ex_pc_i = '0;
      id_ex_alu_op1_i = '0;
      id_ex_alu_op2_i = '0;
      id_ex_alu_fun_i = '0;
      id_ex_mdu_en_i = 1'b0;
      id_ex_rd_idx_i = '0;
      id_ex_rd_en_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset_valid", 64'(ex_valid_o), 64'd0);
      check("reset_result", 64'(ex_result_o), 64'd0);
      check("reset_pc", 64'(ex_pc_o), 64'd0);
      check("reset_rd_idx", 64'(ex_rd_idx_o), 64'd0);
      check("reset_rd_en", 64'(ex_rd_en_o), 64'd0);
      check("reset_stall", 64'(ex_stall_o), 64'd0);

      do_op("add", 1'b0, 4'd0, 32'd5, 32'd7, 0, 32'd12);
      @(posedge clk);
      #1;
      check("idle_valid", 64'(ex_valid_o), 64'd0);
      check("idle_rd_en", 64'(ex_rd_en_o), 64'd0);

      do_op("add_wrap", 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd2, 0, 32'd1);
      do_op("sub", 1'b0, 4'd1, 32'd5, 32'd7, 0, 32'hFFFF_FFFE);
      do_op("sll", 1'b0, 4'd2, 32'd1, 32'd33, 0, 32'd2);
      do_op("slt", 1'b0, 4'd3, 32'd1, 32'hFFFF_FFFF, 0, 32'd0);
      do_op("sltu", 1'b0, 4'd4, 32'd1, 32'hFFFF_FFFF, 0, 32'd1);
      rd_en_drv = 1'b0;
      do_op("xor_nord", 1'b0, 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'h0FF0_0FF0);
      rd_en_drv = 1'b1;
      do_op("srl", 1'b0, 4'd6, 32'h8000_0000, 32'd4, 0, 32'h0800_0000);
      do_op("sra", 1'b0, 4'd7, 32'h8000_0000, 32'd4, 0, 32'hF800_0000);
      do_op("or", 1'b0, 4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hFFF0_FFF0);
      do_op("and", 1'b0, 4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hF000_F000);
      do_op("pass", 1'b0, 4'd10, 32'h1234_5678, 32'hFF00_FF00, 0, 32'hFF00_FF00);
      do_op("fun13", 1'b0, 4'd13, 32'h1234_5678, 32'h0000_0003, 0, 32'd0);

      do_op("mulhu", 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd2, 33, 32'h0000_0001);
      do_op("mul", 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFE);
      do_op("mulh", 1'b1, 4'd1, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000);
      do_op("mulhsu", 1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFF);

      do_op("div_by0", 1'b1, 4'd4, 32'd7, 32'd0, DIV_STALL, DIV_ON ? 32'hFFFF_FFFF : 32'd0);
      do_op("rem_by0", 1'b1, 4'd6, 32'd7, 32'd0, DIV_STALL, DIV_ON ? 32'd7 : 32'd0);
      do_op("div_ovf", 1'b1, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, DIV_STALL, DIV_ON ? 32'h8000_0000 : 32'd0);
      do_op("rem_ovf", 1'b1, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, DIV_STALL, 32'd0);
      do_op("div_neg", 1'b1, 4'd4, 32'hFFFF_FFF9, 32'd2, DIV_STALL, DIV_ON ? 32'hFFFF_FFFD : 32'd0);
      do_op("rem_neg", 1'b1, 4'd6, 32'hFFFF_FFF9, 32'd2, DIV_STALL, DIV_ON ? 32'hFFFF_FFFF : 32'd0);
      do_op("divu", 1'b1, 4'd5, 32'hFFFF_FFF9, 32'd2, DIV_STALL, DIV_ON ? 32'h7FFF_FFFC : 32'd0);
      do_op("remu", 1'b1, 4'd7, 32'hFFFF_FFF9, 32'd2, DIV_STALL, DIV_ON ? 32'd1 : 32'd0);

      @(negedge clk);
      drive(1'b1, 4'd0, 32'd3, 32'd5);
      repeat (10) @(posedge clk);
      #1;
      check("flush_busy_stall", 64'(ex_stall_o), 64'd1);
      flush_i = 1'b1;
      id_ex_valid_i = 1'b0;
      #1;
      check("flush_stall_drop", 64'(ex_stall_o), 64'd0);
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      check("flush_valid", 64'(ex_valid_o), 64'd0);
      check("flush_rd_en", 64'(ex_rd_en_o), 64'd0);
      do_op("add_after_flush", 1'b0, 4'd0, 32'd1, 32'd1, 0, 32'd2);
      vcount = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ex_valid_o) vcount++;
      end
      check("flush_no_late_result", 64'(vcount), 64'd0);

      @(negedge clk);
      drive(1'b1, 4'd3, 32'hFFFF_FFFF, 32'd2);
      repeat (10) @(posedge clk);
      #1;
      check("rst_busy_stall", 64'(ex_stall_o), 64'd1);
      rst = 1'b1;
      id_ex_valid_i = 1'b0;
      #1;
      check("rst_stall_drop", 64'(ex_stall_o), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mid_valid", 64'(ex_valid_o), 64'd0);
      check("rst_mid_result", 64'(ex_result_o), 64'd0);
      check("rst_mid_pc", 64'(ex_pc_o), 64'd0);
      do_op("add_after_rst", 1'b0, 4'd0, 32'd1, 32'd1, 0, 32'd2);
      vcount = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ex_valid_o) vcount++;
      end
      check("rst_no_late_result", 64'(vcount), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
